// File: rtl/fifo_if_pkg.sv
// Shared register-map constants and status layout for the uC <-> USB_CDC FIFO bridge.
package fifo_if_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_IN   = 2'b01;
  localparam logic [1:0] ADDR_STAT = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  localparam int STAT_IN_FULL   = 0;
  localparam int STAT_IN_EMPTY  = 1;
  localparam int STAT_OUT_EMPTY = 2;
  localparam int STAT_OUT_FULL  = 3;
  localparam int STAT_IN_EN     = 4;
  localparam int STAT_OVF       = 5;
  localparam int STAT_UDF       = 6;

  localparam int CTRL_IN_IRQ_EN  = 0;
  localparam int CTRL_OUT_IRQ_EN = 1;

  // Field order mirrors the STAT_* indices, MSB first.
  typedef struct packed {
    logic udf;
    logic ovf;
    logic in_en;
    logic out_full;
    logic out_empty;
    logic in_empty;
    logic in_full;
  } stat_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered level/pointers, head visible combinationally from storage.
// Latency 1 push->head; push refused while full (full sampled before a same-cycle pop).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [$clog2(DEPTH):0] o_level,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fifo_if_buf.sv
// uC 16-bit register bus <-> USB_CDC byte-stream bridge with IN/OUT FIFOs, sticky flags and IRQs.
// Read data latency 1; out_ready_o low while OUT full, IN writes dropped while full or gated.
module fifo_if_buf
  import fifo_if_pkg::*;
#(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter bit IN_GATE   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [1:0]  addr_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic        in_irq_o,
  output logic        out_irq_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o
);

  localparam int IN_LW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_LW = $clog2(OUT_DEPTH) + 1;

  logic              w_rd;
  logic              w_wr;
  logic              w_in_wr;
  logic              w_in_push;
  logic              w_in_drop;
  logic              w_in_pop;
  logic              w_out_push;
  logic              w_out_rd;
  logic              w_out_pop;
  logic              w_out_udf;
  logic              w_clr_ovf;
  logic              w_clr_udf;
  logic              w_in_full;
  logic              w_in_empty;
  logic              w_out_full;
  logic              w_out_empty;
  logic [IN_LW-1:0]  w_in_level;
  logic [OUT_LW-1:0] w_out_level;
  logic [7:0]        w_out_head;
  stat_t             w_stat;
  logic [15:0]       w_rd_dat;
  logic              w_unused;

  logic              r_started;
  logic              r_in_en;
  logic              r_ovf;
  logic              r_udf;
  logic              r_in_irq_en;
  logic              r_out_irq_en;
  logic              r_in_irq;
  logic              r_out_irq;
  logic [15:0]       r_data;

  assign w_rd       = sel_i & read_i;
  assign w_wr       = sel_i & write_i;
  assign w_in_wr    = w_wr & (addr_i == ADDR_IN);
  assign w_in_push  = w_in_wr & r_in_en & ~w_in_full;
  assign w_in_drop  = w_in_wr & ~(r_in_en & ~w_in_full);
  assign w_in_pop   = ~w_in_empty & in_ready_i;
  assign w_out_push = out_valid_i & out_ready_o;
  assign w_out_rd   = w_rd & (addr_i == ADDR_DATA);
  assign w_out_pop  = w_out_rd & ~w_out_empty;
  assign w_out_udf  = w_out_rd & w_out_empty;
  assign w_clr_ovf  = w_wr & (addr_i == ADDR_STAT) & data_i[STAT_OVF];
  assign w_clr_udf  = w_wr & (addr_i == ADDR_STAT) & data_i[STAT_UDF];
  assign w_unused   = ^data_i[15:8];

  sync_fifo #(.WIDTH(8), .DEPTH(IN_DEPTH)) u_in_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_in_push),
    .i_data  (data_i[7:0]),
    .i_pop   (w_in_pop),
    .o_full  (w_in_full),
    .o_empty (w_in_empty),
    .o_level (w_in_level),
    .o_head  (in_data_o)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_out_push),
    .i_data  (out_data_i),
    .i_pop   (w_out_pop),
    .o_full  (w_out_full),
    .o_empty (w_out_empty),
    .o_level (w_out_level),
    .o_head  (w_out_head)
  );

  assign in_valid_o  = ~w_in_empty;
  assign out_ready_o = r_started & ~w_out_full;
  assign in_irq_o    = r_in_irq;
  assign out_irq_o   = r_out_irq;
  assign data_o      = r_data;

  always_comb begin
    w_stat           = '0;
    w_stat.udf       = r_udf;
    w_stat.ovf       = r_ovf;
    w_stat.in_en     = r_in_en;
    w_stat.out_full  = w_out_full;
    w_stat.out_empty = w_out_empty;
    w_stat.in_empty  = w_in_empty;
    w_stat.in_full   = w_in_full;
  end

  always_comb begin
    w_rd_dat = '0;
    case (addr_i)
      ADDR_DATA: w_rd_dat = {8'h00, w_out_head};
      ADDR_STAT: w_rd_dat = {9'b0, w_stat};
      ADDR_CTRL: w_rd_dat = {8'(w_out_level), 8'(w_in_level)};
      default:   w_rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_started    <= 1'b0;
      r_in_en      <= ~IN_GATE;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_in_irq_en  <= 1'b1;
      r_out_irq_en <= 1'b1;
      r_in_irq     <= 1'b0;
      r_out_irq    <= 1'b0;
      r_data       <= '0;
    end else begin
      r_started <= 1'b1;
      r_in_en   <= r_in_en | w_out_push;
      // Setting a sticky flag takes priority over a same-cycle clear.
      r_ovf     <= w_in_drop | (r_ovf & ~w_clr_ovf);
      r_udf     <= w_out_udf | (r_udf & ~w_clr_udf);
      if (w_wr && addr_i == ADDR_CTRL) begin
        r_in_irq_en  <= data_i[CTRL_IN_IRQ_EN];
        r_out_irq_en <= data_i[CTRL_OUT_IRQ_EN];
      end
      r_in_irq  <= w_in_pop & r_in_irq_en;
      r_out_irq <= w_out_push & r_out_irq_en;
      if (w_rd) r_data <= w_rd_dat;
    end
  end

endmodule

// File: tb/tb_fifo_if_buf.sv
// Scoreboard bench for fifo_if_buf at default parameters (depth 4, IN gated until first OUT byte).
module tb_fifo_if_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  addr = 2'b00;
  logic [15:0] wdat = 16'h0000;
  logic [15:0] data_o;
  logic        in_irq_o;
  logic        out_irq_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready = 1'b0;
  logic [7:0]  out_data = 8'h00;
  logic        out_valid = 1'b0;
  logic        out_ready_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_in_irq = 0;
  int n_out_irq = 0;
  logic [7:0]  in_q[$];
  logic [15:0] out_q[$];

  fifo_if_buf #(.IN_DEPTH(4), .OUT_DEPTH(4), .IN_GATE(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .sel_i(sel), .read_i(rd), .write_i(wr),
    .addr_i(addr), .data_i(wdat), .data_o(data_o),
    .in_irq_o(in_irq_o), .out_irq_o(out_irq_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready),
    .out_data_i(out_data), .out_valid_i(out_valid), .out_ready_o(out_ready_o)
  );

  always #5 clk = ~clk;

  // IN stream monitor: every USB-side consume is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && in_valid_o && in_ready) begin
      n_cmp++;
      if (in_q.size() == 0) begin
        n_err++;
        $display("FAIL in_stream: got byte %02h, expected none", in_data_o);
      end else begin
        logic [7:0] exp_b;
        exp_b = in_q.pop_front();
        if (in_data_o !== exp_b) begin
          n_err++;
          $display("FAIL in_stream: got %02h expected %02h", in_data_o, exp_b);
        end
      end
    end
    if (in_irq_o)  n_in_irq++;
    if (out_irq_o) n_out_irq++;
  end

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    sel = 1'b1; wr = 1'b1; addr = a; wdat = d;
    @(posedge clk); #1;
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    sel = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    sel = 1'b0; rd = 1'b0;
    d = data_o;
  endtask

  task automatic usb_send(input logic [7:0] b);
    bit done = 1'b0;
    out_data = b; out_valid = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (out_ready_o) begin
        done = 1'b1;
        out_q.push_back({8'h00, b});
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL usb_send_timeout: byte %02h never accepted, expected accept", b);
    end
    @(posedge clk); #1;
    out_valid = 1'b0;
  endtask

  task automatic drain_in();
    in_ready = 1'b1;
    for (int t = 0; t < 30 && in_q.size() != 0; t++) @(negedge clk);
    @(posedge clk); #1;
    in_ready = 1'b0;
    n_cmp++;
    if (in_q.size() != 0) begin
      n_err++;
      $display("FAIL in_drain_timeout: %0d bytes left, expected 0", in_q.size());
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_ready_o, in_valid_o, in_irq_o, out_irq_o, data_o} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b irq=%b%b data=%04h, expected all 0",
               out_ready_o, in_valid_o, in_irq_o, out_irq_o, data_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL ready_cycle0: got %b expected 0", out_ready_o);
    end
    @(negedge clk);
    n_cmp++;
    if (out_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL ready_cycle1: got %b expected 1", out_ready_o);
    end
  endtask

  task automatic test_in_gate();
    logic [15:0] d;
    bus_write(2'b01, 16'h0041);
    @(negedge clk);
    n_cmp++;
    if (in_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL gate_drop: in_valid got %b expected 0", in_valid_o);
    end
    // ovf, in_en=0, out_empty, in_empty
    bus_read(2'b10, d);
    n_cmp++;
    if (d !== 16'h0026) begin
      n_err++;
      $display("FAIL gate_status: got %04h expected 0026", d);
    end
    bus_write(2'b10, 16'h0020);
    bus_read(2'b10, d);
    n_cmp++;
    if (d !== 16'h0006) begin
      n_err++;
      $display("FAIL gate_ovf_clear: got %04h expected 0006", d);
    end
  endtask

  task automatic test_out_fifo();
    logic [15:0] d;
    int irq0;
    irq0 = n_out_irq;
    for (int i = 0; i < 4; i++) usb_send(8'h10 + 8'(i));
    out_data = 8'h99; out_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (out_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL out_full_ready: got %b expected 0", out_ready_o);
      end
    end
    @(posedge clk); #1;
    out_valid = 1'b0;
    n_cmp++;
    if (n_out_irq - irq0 != 4) begin
      n_err++;
      $display("FAIL out_irq_count: got %0d expected 4", n_out_irq - irq0);
    end
    bus_read(2'b11, d);
    n_cmp++;
    if (d !== 16'h0400) begin
      n_err++;
      $display("FAIL out_level_full: got %04h expected 0400", d);
    end
    while (out_q.size() != 0) begin
      logic [15:0] exp_d;
      exp_d = out_q.pop_front();
      bus_read(2'b00, d);
      n_cmp++;
      if (d !== exp_d) begin
        n_err++;
        $display("FAIL out_read: got %04h expected %04h", d, exp_d);
      end
    end
    bus_read(2'b11, d);
    n_cmp++;
    if (d !== 16'h0000) begin
      n_err++;
      $display("FAIL out_level_empty: got %04h expected 0000", d);
    end
  endtask

  task automatic test_in_fifo();
    logic [15:0] d;
    int irq0;
    irq0 = n_in_irq;
    for (int i = 0; i < 5; i++) begin
      bus_write(2'b01, 16'h00A0 + 16'(i));
      if (in_q.size() < 4) in_q.push_back(8'hA0 + 8'(i));
    end
    bus_read(2'b11, d);
    n_cmp++;
    if (d !== 16'h0004) begin
      n_err++;
      $display("FAIL in_level_full: got %04h expected 0004", d);
    end
    // ovf, in_en, out_empty, in_full
    bus_read(2'b10, d);
    n_cmp++;
    if (d !== 16'h0035) begin
      n_err++;
      $display("FAIL in_full_status: got %04h expected 0035", d);
    end
    drain_in();
    n_cmp++;
    if (n_in_irq - irq0 != 4) begin
      n_err++;
      $display("FAIL in_irq_count: got %0d expected 4", n_in_irq - irq0);
    end
    bus_write(2'b10, 16'h0020);
    bus_read(2'b10, d);
    n_cmp++;
    if (d !== 16'h0016) begin
      n_err++;
      $display("FAIL in_ovf_clear: got %04h expected 0016", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    bus_write(2'b01, 16'h00B0); in_q.push_back(8'hB0);
    bus_write(2'b01, 16'h00B1); in_q.push_back(8'hB1);
    @(posedge clk); #1;
    sel = 1'b1; wr = 1'b1; addr = 2'b01; wdat = 16'h00B2; in_ready = 1'b1;
    in_q.push_back(8'hB2);
    @(posedge clk); #1;
    sel = 1'b0; wr = 1'b0; in_ready = 1'b0;
    bus_read(2'b11, d);
    n_cmp++;
    if (d !== 16'h0002) begin
      n_err++;
      $display("FAIL b2b_level: got %04h expected 0002", d);
    end
    drain_in();
  endtask

  task automatic test_irq_disable();
    logic [15:0] d;
    int in0;
    int out0;
    bus_write(2'b11, 16'h0000);
    in0 = n_in_irq; out0 = n_out_irq;
    usb_send(8'h55);
    bus_write(2'b01, 16'h00C5); in_q.push_back(8'hC5);
    drain_in();
    n_cmp++;
    if (n_in_irq != in0 || n_out_irq != out0) begin
      n_err++;
      $display("FAIL irq_disabled: got in=%0d out=%0d pulses, expected 0 0",
               n_in_irq - in0, n_out_irq - out0);
    end
    bus_read(2'b00, d);
    n_cmp++;
    if (d !== out_q.pop_front()) begin
      n_err++;
      $display("FAIL irqdis_out_read: got %04h expected 0055", d);
    end
    bus_read(2'b00, d);
    n_cmp++;
    if (d !== 16'h0000) begin
      n_err++;
      $display("FAIL empty_read: got %04h expected 0000", d);
    end
    // udf, in_en, out_empty, in_empty
    bus_read(2'b10, d);
    n_cmp++;
    if (d !== 16'h0056) begin
      n_err++;
      $display("FAIL udf_status: got %04h expected 0056", d);
    end
    bus_read(2'b01, d);
    n_cmp++;
    if (d !== 16'h0000) begin
      n_err++;
      $display("FAIL in_addr_read: got %04h expected 0000", d);
    end
  endtask

  initial begin
    test_reset();
    test_in_gate();
    test_out_fifo();
    test_in_fifo();
    test_back_to_back();
    test_irq_disable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
